// File: rtl/ppm_pkg.sv
// Shared types and helpers for the L-PPM frame transmitter: FSM states,
// FIFO entry layout, counter widths and the pulse-slot mapping.
package ppm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } ppm_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } ppm_entry_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int ppm_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // High when the given slot of the current period carries the light pulse.
  function automatic logic ppm_pulse(input ppm_state_e st, input int slot,
                                     input int v, input int l);
    case (st)
      ST_SOF:  return (slot == 0) || (slot == l + 1);
      ST_DATA: return slot == 2 * v + 1;
      ST_EOF:  return slot == l / 2;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ppm_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of {last, data} entries.
// A write while full is taken only when a read frees a slot in the same cycle.
module ppm_tx_fifo
  import ppm_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  ppm_entry_t                  wdata,
  input  logic                        rd,
  output ppm_entry_t                  rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  ppm_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           wr_ok, rd_ok;

  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);
  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/ppm_frame_tx.sv
// L-PPM frame transmitter: buffers byte frames and sends SOF, data symbols
// (LSB-first) and EOF on an active-low optical line.
module ppm_frame_tx
  import ppm_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int SLOT_CLKS    = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic       trunc_err
);

  localparam int L   = 1 << BITS_PER_SYM;
  localparam int SPB = 8 / BITS_PER_SYM;
  localparam int CW  = ppm_cnt_w(SLOT_CLKS);
  localparam int SW  = ppm_cnt_w(2 * L);
  localparam int YW  = ppm_cnt_w(SPB);
  localparam int PW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CLK_LAST      = CW'(SLOT_CLKS - 1);
  localparam logic [SW-1:0] SYM_SLOT_LAST = SW'(2 * L - 1);
  localparam logic [SW-1:0] EOF_SLOT_LAST = SW'(L - 1);
  localparam logic [YW-1:0] SYM_LAST      = YW'(SPB - 1);
  localparam logic [PW-1:0] ALMOST_FULL   = PW'(FIFO_DEPTH - 1);

  ppm_state_e    state;
  logic [CW-1:0] clk_cnt;
  logic [SW-1:0] slot_cnt;
  logic [YW-1:0] sym_cnt;
  logic [7:0]    shreg;
  logic          sh_last;
  logic [PW-1:0] frames_pending;

  ppm_entry_t    fifo_wdata, fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [PW-1:0] fifo_count;

  logic push, pop, forced, start, slot_tick, slot_end, byte_end, pulse;

  assign push = s_valid && s_ready;
  // A byte that fills the FIFO mid-frame closes the frame so it can still be sent.
  assign forced     = push && !s_last && !pop && (fifo_count == ALMOST_FULL);
  assign fifo_wdata = '{last: s_last || forced, data: s_data};

  assign start     = (state == ST_IDLE) && (frames_pending != '0) && !fifo_empty;
  assign slot_tick = clk_cnt == CLK_LAST;
  assign slot_end  = slot_tick &&
                     (slot_cnt == ((state == ST_EOF) ? EOF_SLOT_LAST : SYM_SLOT_LAST));
  assign byte_end  = (state == ST_DATA) && slot_end && (sym_cnt == SYM_LAST);
  assign pop       = start || (byte_end && !sh_last);
  assign pulse     = ppm_pulse(state, int'(slot_cnt), int'(shreg[BITS_PER_SYM-1:0]), L);

  ppm_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .wdata (fifo_wdata),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs are registered from the current state, so the line trails the
  // FSM by one clock; busy and frame_done share that same alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      clk_cnt        <= '0;
      slot_cnt       <= '0;
      sym_cnt        <= '0;
      shreg          <= '0;
      sh_last        <= 1'b0;
      frames_pending <= '0;
      s_ready        <= 1'b0;
      tx_out         <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      trunc_err      <= 1'b0;
    end else begin
      tx_out     <= !pulse;
      busy       <= state != ST_IDLE;
      frame_done <= (state == ST_EOF) && slot_end;
      trunc_err  <= forced;
      s_ready    <= pop || !(fifo_full || (push && fifo_count == ALMOST_FULL));
      frames_pending <= frames_pending + PW'(push && fifo_wdata.last) - PW'(start);

      if (state != ST_IDLE) begin
        clk_cnt <= slot_tick ? '0 : clk_cnt + CW'(1);
        if (slot_tick) slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_SOF;
            {sh_last, shreg} <= fifo_rdata;
          end
        end
        ST_SOF: begin
          if (slot_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (slot_end) begin
            if (sym_cnt == SYM_LAST) begin
              sym_cnt <= '0;
              if (sh_last) state <= ST_EOF;
              else {sh_last, shreg} <= fifo_rdata;
            end else begin
              sym_cnt <= sym_cnt + YW'(1);
              shreg   <= shreg >> BITS_PER_SYM;
            end
          end
        end
        ST_EOF: begin
          if (slot_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
